// File: rtl/instruction_fetch.sv
// Fetch stage: reads instruction words at the bank's PC over a req/ack handshake and
// queues {pc, word} pairs in a small prefetch FIFO for the decoder.
module instruction_fetch #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_read,
  output logic        pc_increment,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic          mem_req_r;
  logic [31:0]   mem_addr_r;
  logic          pc_inc_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [31:0]   data_mem_r [FIFO_DEPTH];
  logic [31:0]   pc_mem_r   [FIFO_DEPTH];

  logic issue_s;
  logic push_s;
  logic pop_s;
  logic pc_low_unused_s;

  // Issue is gated by occupancy sampled in IDLE, so a push can never find the FIFO full.
  assign issue_s = (state_r == IDLE) && !flush && (count_r < FULL_COUNT);
  assign push_s  = (state_r == REQ) && mem_ack && !flush;
  assign pop_s   = (count_r != '0) && instr_ready && !flush;
  assign pc_low_unused_s = ^pc_read[1:0];

  // Next-state logic for the fetch sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (flush) begin
          state_nxt_s = SETTLE;
        end else if (issue_s) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_nxt_s = SETTLE;
        end else if (flush) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = REQ;
        end
      end
      SETTLE: begin
        if (flush) begin
          state_nxt_s = SETTLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          state_nxt_s = SETTLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = SETTLE;
    endcase
  end

  // Sequencer state and registered memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= SETTLE;
      mem_req_r  <= 1'b0;
      mem_addr_r <= 32'h0000_0000;
      pc_inc_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      mem_req_r <= (state_nxt_s == REQ) || (state_nxt_s == DRAIN);
      if (issue_s) begin
        mem_addr_r <= {pc_read[31:2], 2'b00};
      end
      pc_inc_r <= push_s;
    end
  end

  // FIFO pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (!push_s && pop_s) begin
        count_r <= count_r - CW'(1);
      end
    end
  end

  // FIFO storage of fetched words and their fetch addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]   <= 32'h0000_0000;
      end
    end else if (push_s) begin
      data_mem_r[wr_ptr_r] <= mem_rdata;
      pc_mem_r[wr_ptr_r]   <= mem_addr_r;
    end
  end

  // A PC rewrite in the same cycle must not also see an increment.
  assign pc_increment = pc_inc_r & ~flush;
  assign mem_req      = mem_req_r;
  assign mem_addr     = mem_addr_r;
  assign instr_valid  = (count_r != '0);
  assign instr_out    = data_mem_r[rd_ptr_r];
  assign instr_pc     = pc_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: models the PC bank and instruction memory,
// scoreboards fetched {pc, word} pairs in order of arrival at the decoder.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_read;
  logic        pc_increment;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_ready;

  instruction_fetch #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .pc_read(pc_read), .pc_increment(pc_increment),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_out(instr_out),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pop_log[$];
  int push_cnt = 0;
  int inc_cnt = 0;
  int pop_cnt = 0;
  int lat = 0;
  int wait_cnt = 0;
  bit drain_flag = 1'b0;
  bit pushed_now = 1'b0;
  bit inc_seen = 1'b0;
  bit pc_pend = 1'b0;
  bit mono_valid = 1'b0;
  logic [31:0] pc_pend_val = 32'h0;
  logic [31:0] flush_pc = 32'h0;
  logic [31:0] last_pop = 32'h0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Decoder side and flush bookkeeping, evaluated mid-cycle.
  task automatic monitor();
    logic [31:0] e;
    if (rst_n) begin
      if (flush) begin
        if (pushed_now) push_cnt--;
        if (mem_req && !mem_ack) drain_flag = 1'b1;
        exp_q.delete();
        pushed_now  = 1'b0;
        pc_pend     = 1'b1;
        pc_pend_val = flush_pc;
        mono_valid  = 1'b0;
      end else begin
        check("instr_valid", 32'(instr_valid),
              32'((exp_q.size() - int'(pushed_now)) > 0));
        if (instr_valid && instr_ready) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL pop_unexpected: observed pc=0x%08h expected=no word", instr_pc);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("instr_pc", instr_pc, e);
            check("instr_out", instr_out, word_of(e));
          end
          if (mono_valid) check("pc_monotonic", instr_pc, last_pop + 32'd4);
          last_pop   = instr_pc;
          mono_valid = 1'b1;
          pop_log.push_back(instr_pc);
          pop_cnt++;
        end
      end
      if (pc_increment) begin
        inc_cnt++;
        inc_seen = 1'b1;
      end
    end
  endtask

  // PC bank and instruction memory, updated just after the clock edge.
  task automatic env();
    if (!rst_n) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else begin
      pushed_now = 1'b0;
      if (pc_pend) begin
        pc_read = pc_pend_val;
        pc_pend = 1'b0;
      end else if (inc_seen) begin
        pc_read = pc_read + 32'd4;
      end
      inc_seen = 1'b0;
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_req) begin
        if (wait_cnt >= lat) begin
          mem_ack   = 1'b1;
          mem_rdata = word_of(mem_addr);
          if (drain_flag) begin
            drain_flag = 1'b0;
          end else begin
            check("fetch_addr", mem_addr, pc_read);
            exp_q.push_back(pc_read);
            push_cnt++;
            pushed_now = 1'b1;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    env();
  endtask

  task automatic wait_req(input string tag, input int limit);
    int n = 0;
    while (!mem_req && n < limit) begin
      step();
      n++;
    end
    check(tag, 32'(mem_req), 32'd1);
  endtask

  task automatic clear_model();
    exp_q.delete();
    drain_flag = 1'b0;
    pushed_now = 1'b0;
    inc_seen   = 1'b0;
    pc_pend    = 1'b0;
    mono_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int p0;
    int inc_before;
    int push_before;
    logic [31:0] head;

    rst_n = 1'b0; flush = 1'b0; instr_ready = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0; pc_read = 32'h0; lat = 4;
    step(); step();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_pc_increment", 32'(pc_increment), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr_out", instr_out, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);

    // Test 1: first request after reset, then reset asserted mid-request.
    rst_n = 1'b1;
    wait_req("t1_first_req", 20);
    check("t1_addr", mem_addr, 32'h0);
    rst_n = 1'b0;
    #1;
    check("t1_req_drop", 32'(mem_req), 32'd0);
    check("t1_valid_drop", 32'(instr_valid), 32'd0);
    clear_model();
    pc_read = 32'h100; lat = 0; instr_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;

    // Test 2: zero-wait stream from 0x100.
    p0 = pop_cnt; n = 0;
    while (pop_cnt < p0 + 3 && n < 60) begin step(); n++; end
    check("t2_pops", 32'(pop_cnt >= p0 + 3), 32'd1);
    check("t2_word0", pop_log[p0], 32'h100);
    check("t2_word1", pop_log[p0+1], 32'h104);
    check("t2_word2", pop_log[p0+2], 32'h108);

    // Test 3: decoder stalled, fetch stops once the FIFO is full.
    instr_ready = 1'b0;
    repeat (30) step();
    check("t3_req_idle", 32'(mem_req), 32'd0);
    check("t3_valid", 32'(instr_valid), 32'd1);
    check("t3_held", 32'(exp_q.size()), 32'd2);
    check("t3_inc_count", 32'(inc_cnt), 32'(push_cnt));
    head = instr_pc;
    repeat (5) step();
    check("t3_head_stable", instr_pc, head);
    check("t3_head_pc", instr_pc, exp_q[0]);
    check("t3_head_word", instr_out, word_of(exp_q[0]));

    // Test 5: random decoder stalls with zero-wait memory exercise push+pop edges.
    for (int i = 0; i < 80; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      step();
    end
    instr_ready = 1'b0;
    repeat (10) step();
    check("t5_inc_count", 32'(inc_cnt), 32'(push_cnt));

    // Test 4: flush while a slow request is outstanding.
    lat = 3;
    flush_pc = 32'h180; flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4_flush_empties", 32'(instr_valid), 32'd0);
    wait_req("t4_req_0x180", 20);
    check("t4_req_addr", mem_addr, 32'h180);
    inc_before = inc_cnt; push_before = push_cnt;
    flush_pc = 32'h200; flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4_empty", 32'(instr_valid), 32'd0);
    check("t4_drain_req", 32'(mem_req), 32'd1);
    n = 0;
    while (push_cnt == push_before && n < 30) begin step(); n++; end
    check("t4_refetch", 32'(push_cnt), 32'(push_before + 1));
    check("t4_addr", mem_addr, 32'h200);
    check("t4_no_inc", 32'(inc_cnt), 32'(inc_before));
    instr_ready = 1'b1;
    p0 = pop_cnt;
    repeat (15) step();
    check("t4_first_word", pop_log[p0], 32'h200);

    // Test 6: flush coincident with mem_ack and instr_ready.
    lat = 0;
    n = 0;
    while (!(mem_req && mem_ack) && n < 20) begin step(); n++; end
    check("t6_ack_seen", 32'(mem_req && mem_ack), 32'd1);
    flush_pc = 32'h400; flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6_empty", 32'(instr_valid), 32'd0);
    check("t6_no_drain", 32'(mem_req), 32'd0);
    step();
    check("t6_inc_count", 32'(inc_cnt), 32'(push_cnt));
    p0 = pop_cnt; n = 0;
    while (pop_cnt == p0 && n < 20) begin step(); n++; end
    check("t6_first_word", pop_log[p0], 32'h400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
